// File: rtl/sram_mem_controller_if.sv
// ---------------------------------------------------------------------------
// sram_mem_controller_if
// Purpose : bundles the MEM-stage request/response signals and the external
//           16-bit asynchronous SRAM pins used by sram_mem_controller.
// Signals :
//   rd_en, wr_en        load / store request (held until ready=1)
//   address, write_data byte address and store data from EX/MEM
//   read_data           registered load result
//   ready               0 while a transfer is in flight (pipeline freeze)
//   addr_error          one-cycle pulse on a rejected access
//   sram_addr           SRAM half-word address
//   sram_dq_out/_in/_oe split DQ bus with output enable
//   sram_we_n           active-low write strobe
// Modports:
//   slave  : the controller side
//   master : the environment (pipeline plus the SRAM device model), so it
//            also drives sram_dq_in
// ---------------------------------------------------------------------------
interface sram_mem_controller_if #(
  parameter int SRAM_ADDR_W = 18
);
  logic                   rd_en;
  logic                   wr_en;
  logic [31:0]            address;
  logic [31:0]            write_data;
  logic [31:0]            read_data;
  logic                   ready;
  logic                   addr_error;
  logic [SRAM_ADDR_W-1:0] sram_addr;
  logic [15:0]            sram_dq_out;
  logic [15:0]            sram_dq_in;
  logic                   sram_dq_oe;
  logic                   sram_we_n;

  modport slave (
    input  rd_en, wr_en, address, write_data, sram_dq_in,
    output read_data, ready, addr_error, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n
  );

  modport master (
    output rd_en, wr_en, address, write_data, sram_dq_in,
    input  read_data, ready, addr_error, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n
  );
endinterface

// File: rtl/sram_mem_controller.sv
// ---------------------------------------------------------------------------
// sram_mem_controller
// Purpose : MEM-stage controller that splits each 32-bit load/store into two
//           16-bit phases (LOW then HIGH half-word) on an external
//           asynchronous SRAM, each phase lasting WAIT_CYCLES clocks.
//           ready is low while a transfer is in flight.
// Ports   :
//   clk  - rising-edge clock
//   rst  - asynchronous active-low reset
//   bus  - sram_mem_controller_if.slave (request, response and SRAM pins)
// Parameters:
//   WAIT_CYCLES  (2..15) cycles per half-word phase
//   BASE_ADDRESS byte address mapped to SRAM word 0
//   SRAM_ADDR_W  SRAM half-word address width
// Optional feature macro: SRAM_RANGE_CHECK_EN
//   When defined, an address below BASE_ADDRESS or past the end of the SRAM
//   skips the phases, goes straight to DONE with an addr_error pulse and
//   loads read_data with 0. When undefined the address simply wraps.
// ---------------------------------------------------------------------------
module sram_mem_controller #(
  parameter int WAIT_CYCLES  = 3,
  parameter int BASE_ADDRESS = 1024,
  parameter int SRAM_ADDR_W  = 18
) (
  input  logic                  clk,
  input  logic                  rst,
  sram_mem_controller_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

  localparam logic [3:0]  LAST_CNT  = 4'(WAIT_CYCLES - 1);
  localparam logic [31:0] BASE_ADDR = 32'(BASE_ADDRESS);
  localparam int          WORD_W    = SRAM_ADDR_W - 1;

  state_t                 state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic                   is_write_q, is_write_d;
  logic [WORD_W-1:0]      word_q, word_d;
  logic [31:0]            wdata_q, wdata_d;
  logic [31:0]            read_data_q, read_data_d;
  logic [SRAM_ADDR_W-1:0] sram_addr_q, sram_addr_d;
  logic [15:0]            dq_out_q, dq_out_d;
  logic                   dq_oe_q, dq_oe_d;
  logic                   we_n_q, we_n_d;
  logic                   addr_error_q, addr_error_d;

  logic [31:0] offset;
  logic        req;
  logic        reject;
  logic        phase_last;
  logic        unused_bits;

  assign req        = bus.rd_en | bus.wr_en;
  assign offset     = bus.address - BASE_ADDR;
  assign phase_last = (cnt_q == LAST_CNT);
  // Bits above the SRAM range and the byte offset only matter to the range check.
  assign unused_bits = ^offset;

`ifdef SRAM_RANGE_CHECK_EN
  assign reject = (bus.address < BASE_ADDR) || (offset[31:SRAM_ADDR_W+1] != '0);
`else
  assign reject = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      is_write_q   <= 1'b0;
      word_q       <= '0;
      wdata_q      <= '0;
      read_data_q  <= '0;
      sram_addr_q  <= '0;
      dq_out_q     <= '0;
      dq_oe_q      <= 1'b0;
      we_n_q       <= 1'b1;
      addr_error_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      is_write_q   <= is_write_d;
      word_q       <= word_d;
      wdata_q      <= wdata_d;
      read_data_q  <= read_data_d;
      sram_addr_q  <= sram_addr_d;
      dq_out_q     <= dq_out_d;
      dq_oe_q      <= dq_oe_d;
      we_n_q       <= we_n_d;
      addr_error_q <= addr_error_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    is_write_d   = is_write_q;
    word_d       = word_q;
    wdata_d      = wdata_q;
    read_data_d  = read_data_q;
    addr_error_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (req) begin
          // Capture the request so a dropped request still completes cleanly.
          // A simultaneous rd_en/wr_en is treated as a store.
          is_write_d = bus.wr_en;
          word_d     = offset[SRAM_ADDR_W:2];
          wdata_d    = bus.write_data;
          cnt_d      = '0;
          if (reject) begin
            state_d      = DONE;
            addr_error_d = 1'b1;
            read_data_d  = '0;
          end else begin
            state_d = LOW;
          end
        end
      end
      LOW: begin
        if (phase_last) begin
          state_d = HIGH;
          cnt_d   = '0;
          if (!is_write_q) read_data_d[15:0] = bus.sram_dq_in;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      HIGH: begin
        if (phase_last) begin
          state_d = DONE;
          cnt_d   = '0;
          if (!is_write_q) read_data_d[31:16] = bus.sram_dq_in;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Pin outputs are registered, so they are derived from the state and
    // count the controller is about to enter.
    sram_addr_d = sram_addr_q;
    dq_out_d    = dq_out_q;
    dq_oe_d     = 1'b0;
    we_n_d      = 1'b1;
    if (state_d == LOW || state_d == HIGH) begin
      sram_addr_d = {word_d, state_d == HIGH};
      if (is_write_d) begin
        dq_oe_d  = 1'b1;
        dq_out_d = (state_d == HIGH) ? wdata_d[31:16] : wdata_d[15:0];
        // Strobe rises for the last phase cycle so data/address are held
        // across the rising edge of we_n.
        we_n_d   = (cnt_d == LAST_CNT);
      end
    end
  end

  assign bus.ready       = (state_q == IDLE) ? ~req : (state_q == DONE);
  assign bus.read_data   = read_data_q;
  assign bus.addr_error  = addr_error_q;
  assign bus.sram_addr   = sram_addr_q;
  assign bus.sram_dq_out = dq_out_q;
  assign bus.sram_dq_oe  = dq_oe_q;
  assign bus.sram_we_n   = we_n_q;

endmodule

// File: tb/tb_sram_mem_controller.sv
// ---------------------------------------------------------------------------
// tb_sram_mem_controller
// Directed stimulus for sram_mem_controller with a transaction-level model
// that expands each access into its expected per-cycle pin/handshake trace,
// a per-cycle compare process, and a behavioural SRAM device.
// ---------------------------------------------------------------------------
module tb_sram_mem_controller;
  localparam int W       = 3;
  localparam int BASE    = 1024;
  localparam int AW      = 18;
  localparam int TXN_LEN = 2 * W + 2;

  typedef struct {
    logic          ready;
    logic          chk_addr;
    logic [AW-1:0] addr;
    logic          oe;
    logic          we_n;
    logic          chk_dq;
    logic [15:0]   dq;
    logic          chk_rd;
    logic [31:0]   rd;
    logic          err;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  bit   run = 1'b0;

  sram_mem_controller_if #(.SRAM_ADDR_W(AW)) bus ();

  sram_mem_controller #(
    .WAIT_CYCLES (W),
    .BASE_ADDRESS(BASE),
    .SRAM_ADDR_W (AW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  exp_t        exp_q[$];
  logic [31:0] exp_rd = '0;
  logic [15:0] model_mem [int];
  logic [15:0] sram_mem  [int];

  logic          tr_ready [TXN_LEN];
  logic [AW-1:0] tr_addr  [TXN_LEN];
  logic [15:0]   tr_dq    [TXN_LEN];
  logic          tr_we_n  [TXN_LEN];
  logic [31:0]   tr_rd    [TXN_LEN];
  logic          tr_err   [TXN_LEN];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] model_rd(input int a);
    return model_mem.exists(a) ? model_mem[a] : 16'h0000;
  endfunction

  // SRAM device: latches data on the rising write strobe, drives read data
  // for the current address.
  always @(posedge bus.sram_we_n)
    if (rst === 1'b1) sram_mem[int'(bus.sram_addr)] = bus.sram_dq_out;

  always @(negedge clk)
    bus.sram_dq_in = sram_mem.exists(int'(bus.sram_addr)) ? sram_mem[int'(bus.sram_addr)] : 16'h0000;

  // Expand one access into its expected cycle trace; returns its length.
  function automatic int build(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] word;
    logic [31:0] nrd;
    int          lo;
    bit          rej;
    exp_t        e;
    if (!rd && !wr) return 0;
    word = (a - 32'(BASE)) >> 2;
    lo   = int'((word << 1) & 32'((1 << AW) - 1));
    rej  = 1'b0;
`ifdef SRAM_RANGE_CHECK_EN
    rej  = (a < 32'(BASE)) || (word >= 32'(1 << (AW - 1)));
`endif
    e = '{ready:1'b0, chk_addr:1'b0, addr:'0, oe:1'b0, we_n:1'b1, chk_dq:1'b0,
          dq:'0, chk_rd:1'b1, rd:exp_rd, err:1'b0};
    exp_q.push_back(e);
    if (rej) begin
      e.ready = 1'b1;
      e.err   = 1'b1;
      e.rd    = '0;
      exp_rd  = '0;
      exp_q.push_back(e);
      return 2;
    end
    nrd = wr ? exp_rd : {model_rd(lo + 1), model_rd(lo)};
    for (int k = 1; k <= 2 * W; k++) begin
      int p;
      int j;
      p = (k - 1) / W;
      j = (k - 1) % W;
      e.ready    = 1'b0;
      e.chk_addr = 1'b1;
      e.addr     = AW'(lo + p);
      e.oe       = wr;
      e.we_n     = wr ? (j == W - 1) : 1'b1;
      e.chk_dq   = wr;
      e.dq       = (p == 1) ? d[31:16] : d[15:0];
      e.chk_rd   = wr;
      e.rd       = exp_rd;
      e.err      = 1'b0;
      exp_q.push_back(e);
    end
    e.ready    = 1'b1;
    e.chk_addr = 1'b0;
    e.oe       = 1'b0;
    e.we_n     = 1'b1;
    e.chk_dq   = 1'b0;
    e.chk_rd   = 1'b1;
    e.rd       = nrd;
    exp_q.push_back(e);
    if (wr) begin
      model_mem[lo]     = d[15:0];
      model_mem[lo + 1] = d[31:16];
    end
    exp_rd = nrd;
    return TXN_LEN;
  endfunction

  // Per-cycle compare against the model; idle cycles expect a quiet bus.
  always @(negedge clk) begin : cmp
    exp_t e;
    if (rst === 1'b1 && run) begin
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
      end else begin
        e = '{ready:1'b1, chk_addr:1'b0, addr:'0, oe:1'b0, we_n:1'b1, chk_dq:1'b0,
              dq:'0, chk_rd:1'b1, rd:exp_rd, err:1'b0};
      end
      chk("ready", 32'(bus.ready), 32'(e.ready));
      chk("dq_oe", 32'(bus.sram_dq_oe), 32'(e.oe));
      chk("we_n", 32'(bus.sram_we_n), 32'(e.we_n));
      chk("addr_error", 32'(bus.addr_error), 32'(e.err));
      if (e.chk_addr) chk("sram_addr", 32'(bus.sram_addr), 32'(e.addr));
      if (e.chk_dq)   chk("dq_out", 32'(bus.sram_dq_out), 32'(e.dq));
      if (e.chk_rd)   chk("read_data", bus.read_data, e.rd);
    end
  end

  task automatic txn(input logic rd, input logic wr, input logic [31:0] a,
                     input logic [31:0] d, input bit hold_after);
    int n;
    bus.rd_en      = rd;
    bus.wr_en      = wr;
    bus.address    = a;
    bus.write_data = d;
    n = build(rd, wr, a, d);
    for (int k = 0; k < n; k++) begin
      #1;
      tr_ready[k] = bus.ready;
      tr_addr[k]  = bus.sram_addr;
      tr_dq[k]    = bus.sram_dq_out;
      tr_we_n[k]  = bus.sram_we_n;
      tr_rd[k]    = bus.read_data;
      tr_err[k]   = bus.addr_error;
      @(posedge clk);
      #1;
    end
    $display("txn rd=%0b wr=%0b addr=%0d wdata=%h -> read_data=%h", rd, wr, a, d, bus.read_data);
    if (!hold_after) begin
      bus.rd_en = 1'b0;
      bus.wr_en = 1'b0;
    end
  endtask

  function automatic int first_ready();
    for (int k = 0; k < TXN_LEN; k++) if (tr_ready[k]) return k;
    return -1;
  endfunction

  task automatic chk_reset_values(input string tag);
    chk({tag, "_ready"}, 32'(bus.ready), 32'd1);
    chk({tag, "_read_data"}, bus.read_data, 32'h0);
    chk({tag, "_sram_addr"}, 32'(bus.sram_addr), 32'h0);
    chk({tag, "_dq_out"}, 32'(bus.sram_dq_out), 32'h0);
    chk({tag, "_dq_oe"}, 32'(bus.sram_dq_oe), 32'd0);
    chk({tag, "_we_n"}, 32'(bus.sram_we_n), 32'd1);
    chk({tag, "_addr_error"}, 32'(bus.addr_error), 32'd0);
  endtask

  initial begin
    int we_low;
    bus.rd_en      = 1'b0;
    bus.wr_en      = 1'b0;
    bus.address    = '0;
    bus.write_data = '0;
    #2 rst = 1'b0;
    #10;
    chk_reset_values("reset");
    @(posedge clk); #1;
    rst = 1'b1;
    run = 1'b1;
    repeat (2) begin @(posedge clk); #1; end

    // Store 0xDEADBEEF at 1024.
    txn(1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, 1'b0);
    chk("wr_ready_cycle", 32'(first_ready()), 32'd7);
    chk("wr_addr_low", 32'(tr_addr[1]), 32'h0);
    chk("wr_addr_high", 32'(tr_addr[W + 1]), 32'h1);
    chk("wr_dq_low", 32'(tr_dq[1]), 32'h0000BEEF);
    chk("wr_dq_high", 32'(tr_dq[W + 1]), 32'h0000DEAD);
    we_low = 0;
    for (int k = 0; k < TXN_LEN; k++) if (!tr_we_n[k]) we_low++;
    chk("wr_we_low_cycles", 32'(we_low), 32'd4);

    // Load it back.
    txn(1'b1, 1'b0, 32'd1024, 32'h0, 1'b0);
    chk("rd_done_data", tr_rd[2 * W + 1], 32'hDEADBEEF);
    @(posedge clk); #1;
    chk("rd_data_held", bus.read_data, 32'hDEADBEEF);

    // rd_en and wr_en together act as a store.
    txn(1'b1, 1'b1, 32'd1028, 32'h12345678, 1'b0);
    chk("both_addr_low", 32'(tr_addr[1]), 32'h2);
    chk("both_addr_high", 32'(tr_addr[W + 1]), 32'h3);
    chk("both_dq_low", 32'(tr_dq[1]), 32'h00005678);
    chk("both_rd_unchanged", tr_rd[2 * W + 1], 32'hDEADBEEF);

    // Address just below the SRAM window.
    txn(1'b0, 1'b1, 32'd1020, 32'hA5A55A5A, 1'b0);
`ifdef SRAM_RANGE_CHECK_EN
    chk("oob_ready_cycle", 32'(first_ready()), 32'd1);
    chk("oob_addr_error", 32'(tr_err[1]), 32'd1);
    chk("oob_we_n", 32'(tr_we_n[0] & tr_we_n[1]), 32'd1);
`else
    chk("wrap_addr_low", 32'(tr_addr[1]), 32'h3FFFE);
    chk("wrap_addr_high", 32'(tr_addr[W + 1]), 32'h3FFFF);
    txn(1'b1, 1'b0, 32'd1020, 32'h0, 1'b0);
    chk("wrap_readback", tr_rd[2 * W + 1], 32'hA5A55A5A);
`endif

    // Back-to-back load then store with requests held through DONE.
    txn(1'b1, 1'b0, 32'd1028, 32'h0, 1'b1);
    chk("b2b_load", tr_rd[2 * W + 1], 32'h12345678);
    txn(1'b0, 1'b1, 32'd1032, 32'h0F0F1234, 1'b0);
    chk("b2b_store_ready_cycle", 32'(first_ready()), 32'd7);
    txn(1'b1, 1'b0, 32'd1032, 32'h0, 1'b0);
    chk("b2b_readback", tr_rd[2 * W + 1], 32'h0F0F1234);

    // Reset in the middle of the HIGH phase of a store.
    bus.wr_en      = 1'b1;
    bus.address    = 32'd1040;
    bus.write_data = 32'hCAFEF00D;
    void'(build(1'b0, 1'b1, 32'd1040, 32'hCAFEF00D));
    repeat (W + 2) begin @(posedge clk); #1; end
    exp_q.delete();
    rst       = 1'b0;
    bus.wr_en = 1'b0;
    #1;
    chk_reset_values("midreset");
    $display("txn reset during HIGH phase of store at 1040");
    exp_rd = '0;
    model_mem.delete(8);
    model_mem.delete(9);
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    chk("post_reset_ready", 32'(bus.ready), 32'd1);

    txn(1'b1, 1'b0, 32'd1032, 32'h0, 1'b0);
    chk("post_reset_load", tr_rd[2 * W + 1], 32'h0F0F1234);

    repeat (3) begin @(posedge clk); #1; end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
